stream_case_conv: RTL and testbench
===================================

Name: stream_case_conv

Overview:
Streaming, parametrised successor of the 8-bit combinational lowercase-to-uppercase converter. It converts LANES ASCII bytes per beat and supports four modes: pass, upper, lower and toggle. A valid/ready handshake with a skid buffer lets it sit between a byte source (UART RX / FIFO) and a byte sink. It also keeps a saturating count of the characters it changed.

Parameters:
LANES, 4, bytes per beat; legal range 1..16; lane i occupies data bits [8i+7:8i].
CNT_W, 16, width of the converted-character counter.

Ports:
clk  in  1  system clock; all logic is rising-edge.
rst  in  1  synchronous, active-high reset.
mode  in  2  00 pass, 01 upper, 10 lower, 11 toggle; sampled together with each accepted beat.
in_valid  in  1  input beat valid.
in_ready  out  1  block can accept a beat.
in_data  in  8*LANES  input bytes.
in_last  in  1  end-of-message marker; travels with the beat.
out_valid  out  1  output beat valid.
out_ready  in  1  sink accepts the beat.
out_data  out  8*LANES  converted bytes.
out_last  out  1  in_last of the same beat.
clr_count  in  1  synchronous clear of conv_count.
conv_count  out  CNT_W  saturating count of bytes changed by conversion.

Behaviour:
- Byte function, applied per lane:
  - upper: 0x61..0x7A -> byte-0x20.
  - lower: 0x41..0x5A -> byte+0x20.
  - toggle: applies both rules.
  - pass: identity.
  - All other bytes are unchanged, including 0x40, 0x5B, 0x60, 0x7B and 0x80..0xFF.
- Conversion is computed at acceptance, using the mode value present in the accept cycle. The stored beat is already converted, so a later mode change never alters a beat that has already been accepted.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready = !rst & !skid_valid. This is a registered-state function with no combinational path from out_ready.
- Storage is an output register plus one skid register. States:
  - EMPTY: out_valid=0.
  - ONE: out_valid=1, skid empty.
  - FULL: out_valid=1, skid valid, in_ready=0.
- Transitions:
  - EMPTY + accept -> ONE; the beat appears on out_* the next cycle. Latency is 1 cycle.
  - ONE + accept + transfer -> ONE, and the output register takes the new beat.
  - ONE + accept + no transfer -> FULL, and the beat goes to the skid.
  - ONE + transfer only -> EMPTY.
  - FULL + transfer -> ONE, and the skid moves to the output register. No accept is possible in FULL.
- Ordering is strictly FIFO. Throughput is 1 beat/cycle when out_ready is held high.
- While out_valid=1 and out_ready=0, out_data and out_last are stable.
- conv_count:
  - On each accept it adds the number of lanes whose byte changed (0..LANES).
  - It saturates at 2^CNT_W-1.
  - clr_count=1 forces 0 in that cycle and discards any same-cycle increment.
- Reset, synchronous and valid mid-operation:
  - Next cycle: out_valid=0, out_data=0, out_last=0, skid cleared, conv_count=0, state EMPTY.
  - in_ready=0 during every cycle rst is high; any beats in flight are dropped.
- out_data/out_last are don't-care-free: they hold their last value when out_valid=0, and hold 0 after reset.

Test Plan:
- LANES=4, mode=01, in_data=0x7A_60_61_41 (lane3..lane0), out_ready=1 -> out_data=0x5A_60_41_41 one cycle later; conv_count=2.
- mode=11, in_data=0x5B_40_7B_80 -> out_data unchanged; conv_count+=0. Then mode=11, in_data=0x6D_4D_68_48 -> 0x4D_6D_48_68; conv_count+=4.
- Backpressure: out_ready=0, two beats sent A (last=0), B (last=1) -> in_ready drops after B, out_data=A held stable. Raise out_ready -> A then B on consecutive cycles, out_last=0 then 1, and in_ready returns 1.
- Mode change while stalled: accept beat 0x61616161 under mode=01, hold out_ready=0, switch mode to 10 -> output is still 0x41414141.
- Counter: CNT_W=4, feed 5 beats of 0x61616161 in upper mode -> conv_count saturates at 15. Assert clr_count together with another accept -> conv_count=0 next cycle.
- Reset mid-stream in FULL state -> next cycle out_valid=0, conv_count=0, in_ready=1 once rst falls, and no stale beat emerges.

Source files
------------

// File: rtl/stream_case_conv.sv
// -----------------------------------------------------------------------------
// stream_case_conv
//   Streaming ASCII case converter. Each beat carries LANES bytes (lane i is
//   data[8i+7:8i]). Every byte is converted on acceptance according to mode:
//     00 pass, 01 upper (a-z -> A-Z), 10 lower (A-Z -> a-z), 11 toggle (both).
//   A two-entry output stage (output register + skid register) decouples
//   in_ready from out_ready, so in_ready is a pure function of registered
//   state (plus rst). A saturating counter tracks how many bytes were changed.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   mode[1:0]             conversion mode, sampled with each accepted beat
//   in_valid/in_ready     input handshake
//   in_data, in_last      input beat and end-of-message marker
//   out_valid/out_ready   output handshake
//   out_data, out_last    converted beat and its marker
//   clr_count             synchronous clear of conv_count (wins over increment)
//   conv_count            saturating count of converted bytes
// -----------------------------------------------------------------------------
module stream_case_conv #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_last,
  input  logic               clr_count,
  output logic [CNT_W-1:0]   conv_count
);

  // LANES <= 16, so a per-beat changed-lane count fits in 5 bits.
  localparam int NUM_W = 5;
  localparam int SUM_W = CNT_W + NUM_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [8*LANES-1:0] out_data_q,  out_data_d;
  logic               out_last_q,  out_last_d;
  logic [8*LANES-1:0] skid_data_q, skid_data_d;
  logic               skid_last_q, skid_last_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;

  logic [8*LANES-1:0] conv_data;
  logic [LANES-1:0]   lane_changed;
  logic [NUM_W-1:0]   changed_num;
  logic [SUM_W-1:0]   count_sum;
  logic               accept;
  logic               xfer;

  // ---------------------------------------------------------------------------
  // Per-lane byte conversion. mode[0] enables the upper rule, mode[1] the lower
  // rule; toggle (11) enables both, and the two ranges never overlap.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] lane_byte;
    logic       is_lower;
    logic       is_upper;
    logic       do_up;
    logic       do_lo;

    assign lane_byte = in_data[8*gi +: 8];
    assign is_lower  = (lane_byte >= 8'h61) && (lane_byte <= 8'h7A);
    assign is_upper  = (lane_byte >= 8'h41) && (lane_byte <= 8'h5A);
    assign do_up     = mode[0] & is_lower;
    assign do_lo     = mode[1] & is_upper;

    assign conv_data[8*gi +: 8] = do_up ? (lane_byte - 8'h20) :
                                  do_lo ? (lane_byte + 8'h20) : lane_byte;
    assign lane_changed[gi]     = do_up | do_lo;
  end

  always_comb begin
    changed_num = '0;
    for (int i = 0; i < LANES; i++) begin
      changed_num = changed_num + NUM_W'(lane_changed[i]);
    end
  end

  // Widened sum so the saturation test cannot wrap.
  assign count_sum = {{NUM_W{1'b0}}, cnt_q} + {{CNT_W{1'b0}}, changed_num};

  // ---------------------------------------------------------------------------
  // Handshake. FULL is exactly "skid holds a beat", so in_ready depends only
  // on registered state and rst.
  // ---------------------------------------------------------------------------
  assign in_ready  = !rst && (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_data_d = conv_data;
          out_last_d = in_last;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          out_data_d = conv_data;
          out_last_d = in_last;
        end else if (accept) begin
          skid_data_d = conv_data;
          skid_last_d = in_last;
          state_d     = ST_FULL;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain path exists.
        if (xfer) begin
          out_data_d = skid_data_q;
          out_last_d = skid_last_q;
          state_d    = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (clr_count) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = (count_sum > {{NUM_W{1'b0}}, CNT_MAX}) ? CNT_MAX : count_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign conv_count = cnt_q;

endmodule

// File: tb/tb_stream_case_conv.sv
// -----------------------------------------------------------------------------
// tb_stream_case_conv
//   Two instances share all inputs: dut (CNT_W=16) and dut_s (CNT_W=4) so the
//   counter saturation can be observed quickly. The reference model treats the
//   block as a 2-deep FIFO of already-converted beats.
// -----------------------------------------------------------------------------
module tb_stream_case_conv;

  localparam int LANES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready, in_ready_s;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid, out_valid_s;
  logic        out_ready;
  logic [31:0] out_data, out_data_s;
  logic        out_last, out_last_s;
  logic        clr_count;
  logic [15:0] conv_count;
  logic [3:0]  conv_count_s;

  always #5 clk = ~clk;

  stream_case_conv #(.LANES(LANES), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .clr_count(clr_count), .conv_count(conv_count)
  );

  stream_case_conv #(.LANES(LANES), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_last(out_last_s),
    .clr_count(clr_count), .conv_count(conv_count_s)
  );

  // Reference model state
  logic [32:0] exp_q[$];      // {last, data} of beats held inside the block
  logic [32:0] held;          // what out_* shows when nothing is valid
  int          cnt16;
  int          cnt4;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Case conversion straight from the character rules.
  function automatic logic [31:0] model_conv(input logic [1:0] m, input logic [31:0] d,
                                             output int n);
    logic [31:0] res;
    int c, r;
    n = 0;
    for (int i = 0; i < LANES; i++) begin
      c = int'(d[8*i +: 8]);
      r = c;
      if ((m == 2'b01 || m == 2'b11) && c >= 97 && c <= 122) r = c - 32;
      if ((m == 2'b10 || m == 2'b11) && c >= 65 && c <= 90)  r = c + 32;
      if (r != c) n++;
      res[8*i +: 8] = 8'(r);
    end
    return res;
  endfunction

  // One clock cycle: drive at the falling edge, compare, advance model, clock.
  task automatic step(input logic r, input logic [1:0] m, input logic v,
                      input logic [31:0] d, input logic l, input logic ordy,
                      input logic clr);
    logic        exp_ready, exp_valid, acc, xf;
    logic [31:0] cd;
    int          n;
    rst = r; mode = m; in_valid = v; in_data = d; in_last = l;
    out_ready = ordy; clr_count = clr;
    #1;
    exp_ready = !r && (exp_q.size() < 2);
    exp_valid = (exp_q.size() > 0);
    check("in_ready",   64'(in_ready),   64'(exp_ready));
    check("out_valid",  64'(out_valid),  64'(exp_valid));
    if (exp_valid) begin
      check("out_data", 64'(out_data), 64'(exp_q[0][31:0]));
      check("out_last", 64'(out_last), 64'(exp_q[0][32]));
    end else begin
      check("held_data", 64'(out_data), 64'(held[31:0]));
      check("held_last", 64'(out_last), 64'(held[32]));
    end
    check("count16", 64'(conv_count),   64'(cnt16));
    check("count4",  64'(conv_count_s), 64'(cnt4));

    acc = v && exp_ready;
    xf  = exp_valid && ordy;
    if (r) begin
      exp_q.delete();
      held  = '0;
      cnt16 = 0;
      cnt4  = 0;
    end else begin
      if (xf) held = exp_q.pop_front();
      cd = model_conv(m, d, n);
      if (acc) exp_q.push_back({l, cd});
      if (clr) begin
        cnt16 = 0;
        cnt4  = 0;
      end else if (acc) begin
        cnt16 = (cnt16 + n > 65535) ? 65535 : cnt16 + n;
        cnt4  = (cnt4 + n > 15) ? 15 : cnt4 + n;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_data();
    logic [31:0] d;
    for (int i = 0; i < LANES; i++) begin
      if ($urandom_range(0, 3) == 0) d[8*i +: 8] = 8'($urandom_range(0, 255));
      else                            d[8*i +: 8] = 8'($urandom_range(8'h3E, 8'h7D));
    end
    return d;
  endfunction

  initial begin
    held = '0; cnt16 = 0; cnt4 = 0;
    rst = 1'b1; mode = 2'b00; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b0; clr_count = 1'b0;
    @(negedge clk);
    step(1, 2'b00, 0, 32'h0, 0, 0, 0);
    step(1, 2'b00, 0, 32'h0, 0, 0, 0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data),  64'd0);

    // Upper mode, boundary bytes around 'a'/'z'
    step(0, 2'b01, 1, 32'h7A606141, 0, 1, 0);
    check("tp1_data",  64'(out_data),   64'h5A604141);
    check("tp1_count", 64'(conv_count), 64'd2);

    // Toggle mode: non-letters untouched, then letters swapped
    step(0, 2'b11, 1, 32'h5B407B80, 0, 1, 0);
    check("tp2a_data",  64'(out_data),   64'h5B407B80);
    check("tp2a_count", 64'(conv_count), 64'd2);
    step(0, 2'b11, 1, 32'h6D4D6848, 0, 1, 0);
    check("tp2b_data",  64'(out_data),   64'h4D6D4868);
    check("tp2b_count", 64'(conv_count), 64'd6);
    step(0, 2'b00, 0, 32'h0, 0, 1, 0);

    // Backpressure: A then B with sink stalled
    step(0, 2'b00, 1, 32'h11111111, 0, 0, 0);
    step(0, 2'b00, 1, 32'h22222222, 1, 0, 0);
    check("bp_ready", 64'(in_ready), 64'd0);
    check("bp_hold",  64'(out_data), 64'h11111111);
    step(0, 2'b00, 0, 32'h0, 0, 0, 0);
    step(0, 2'b00, 0, 32'h0, 0, 1, 0);
    check("bp_b_data", 64'(out_data), 64'h22222222);
    check("bp_b_last", 64'(out_last), 64'd1);
    step(0, 2'b00, 0, 32'h0, 0, 1, 0);
    check("bp_drain_ready", 64'(in_ready), 64'd1);

    // Mode change while stalled does not touch the stored beat
    step(0, 2'b01, 1, 32'h61616161, 0, 0, 0);
    step(0, 2'b10, 0, 32'h0, 0, 0, 0);
    step(0, 2'b10, 0, 32'h0, 0, 0, 0);
    check("stall_mode", 64'(out_data), 64'h41414141);
    step(0, 2'b10, 0, 32'h0, 0, 1, 0);

    // Saturation on the 4-bit counter, then clear against an accept
    step(0, 2'b00, 0, 32'h0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 2'b01, 1, 32'h61616161, 0, 1, 0);
    check("sat4", 64'(conv_count_s), 64'd15);
    step(0, 2'b01, 1, 32'h61616161, 0, 1, 1);
    check("clr16", 64'(conv_count),   64'd0);
    check("clr4",  64'(conv_count_s), 64'd0);

    // Reset while FULL
    step(0, 2'b01, 1, 32'h61626364, 0, 0, 0);
    step(0, 2'b01, 1, 32'h65666768, 1, 0, 0);
    step(1, 2'b01, 1, 32'h696A6B6C, 0, 0, 0);
    check("rst_full_valid", 64'(out_valid),  64'd0);
    check("rst_full_count", 64'(conv_count), 64'd0);
    step(0, 2'b01, 0, 32'h0, 0, 1, 0);
    step(0, 2'b01, 0, 32'h0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 7),
           rand_data(),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 99) < 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
